imm_narrow_seq: RTL and testbench

Sequential sign-narrowing unit: the inverse of the datapath's 6-to-32-bit immediate sign extension. It takes a 32-bit signed word, checks bit-serially whether it is representable as a 6-bit two's-complement immediate, and returns the narrowed field with a fits flag, optionally saturated. It sits on the assembler/immediate-encode side of the datapath, feeding 6-bit immediate fields. It keeps a running count of non-representable conversions.

---
 rtl/imm_narrow_seq_if.sv | 26 ++
 rtl/imm_narrow_seq.sv | 93 +++++++++
 tb/tb_imm_narrow_seq.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/imm_narrow_seq_if.sv
// Request/result bundle for the sequential immediate narrower.
// The master drives a conversion request; the slave returns the narrowed field and status.
interface imm_narrow_seq_if #(
    parameter int IN_W  = 32,
    parameter int OUT_W = 6,
    parameter int CNT_W = 8
);
    logic             start;
    logic [IN_W-1:0]  data_in;
    logic             sat_en;
    logic             busy;
    logic             done;
    logic [OUT_W-1:0] result_out;
    logic             fits;
    logic [CNT_W-1:0] ovf_count;

    modport master (
        output start, data_in, sat_en,
        input  busy, done, result_out, fits, ovf_count
    );

    modport slave (
        input  start, data_in, sat_en,
        output busy, done, result_out, fits, ovf_count
    );
endinterface

// File: rtl/imm_narrow_seq.sv
// Bit-serial check of whether a signed word fits an OUT_W-bit immediate, with
// optional saturation and a saturating count of non-representable conversions.
module imm_narrow_seq #(
    parameter int IN_W  = 32,
    parameter int OUT_W = 6,
    parameter int CNT_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    imm_narrow_seq_if.slave   bus
);
    localparam int UW = IN_W - OUT_W;
    localparam int CW = $clog2(UW + 1);
    localparam logic [CW-1:0]    LAST_CNT = CW'(UW - 1);
    localparam logic [OUT_W-1:0] MOST_NEG = {1'b1, {(OUT_W-1){1'b0}}};
    localparam logic [OUT_W-1:0] MOST_POS = {1'b0, {(OUT_W-1){1'b1}}};

    typedef enum logic {IDLE, SCAN} state_t;

    state_t           state_q;
    logic [UW-1:0]    upper_q;
    logic [OUT_W-1:0] lowField_q;
    logic             satEn_q;
    logic             refBit_q;
    logic             mismatch_q;
    logic [CW-1:0]    cnt_q;
    logic             done_q;
    logic [OUT_W-1:0] result_q;
    logic             fits_q;
    logic [CNT_W-1:0] ovfCount_q;

    logic             scanMismatch_d;
    logic             fits_d;
    logic [OUT_W-1:0] result_d;

    // Upper bits are shifted arithmetically so the MSB keeps the input's sign for saturation.
    assign scanMismatch_d = upper_q[0] ^ refBit_q;
    assign fits_d         = !(mismatch_q | scanMismatch_d);
    assign result_d       = (fits_d || !satEn_q) ? lowField_q
                          : (upper_q[UW-1] ? MOST_NEG : MOST_POS);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            upper_q    <= '0;
            lowField_q <= '0;
            satEn_q    <= 1'b0;
            refBit_q   <= 1'b0;
            mismatch_q <= 1'b0;
            cnt_q      <= '0;
            done_q     <= 1'b0;
            result_q   <= '0;
            fits_q     <= 1'b0;
            ovfCount_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        upper_q    <= bus.data_in[IN_W-1:OUT_W];
                        lowField_q <= bus.data_in[OUT_W-1:0];
                        satEn_q    <= bus.sat_en;
                        refBit_q   <= bus.data_in[OUT_W-1];
                        mismatch_q <= 1'b0;
                        cnt_q      <= '0;
                        state_q    <= SCAN;
                    end
                end
                SCAN: begin
                    mismatch_q <= mismatch_q | scanMismatch_d;
                    upper_q    <= UW'($signed(upper_q) >>> 1);
                    cnt_q      <= cnt_q + 1'b1;
                    if (cnt_q == LAST_CNT) begin
                        state_q  <= IDLE;
                        done_q   <= 1'b1;
                        fits_q   <= fits_d;
                        result_q <= result_d;
                        if (!fits_d && ovfCount_q != '1) begin
                            ovfCount_q <= ovfCount_q + 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.busy       = (state_q == SCAN);
    assign bus.done       = done_q;
    assign bus.result_out = result_q;
    assign bus.fits       = fits_q;
    assign bus.ovf_count  = ovfCount_q;
endmodule

// File: tb/tb_imm_narrow_seq.sv
// Directed bench for imm_narrow_seq: a countdown/arithmetic model checked every
// cycle, plus hand-computed literal expectations for each scenario.
module tb_imm_narrow_seq;
    localparam int N = 26;

    logic clk;
    logic reset;
    int   compared;
    int   mismatched;
    bit   checkEn;
    int   doneSeen;

    imm_narrow_seq_if busIf ();

    imm_narrow_seq dut (
        .clk   (clk),
        .reset (reset),
        .bus   (busIf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: a pending conversion is a countdown plus a precomputed answer from signed range arithmetic.
    int         mBusyLeft;
    bit         mDone;
    logic [5:0] mResult;
    bit         mFits;
    int         mOvf;
    logic [5:0] pendResult;
    bit         pendFits;

    always @(posedge clk) begin
        int v;
        if (reset) begin
            mBusyLeft = 0;
            mDone     = 0;
            mResult   = '0;
            mFits     = 0;
            mOvf      = 0;
        end else begin
            mDone = 0;
            if (mBusyLeft > 0) begin
                mBusyLeft = mBusyLeft - 1;
                if (mBusyLeft == 0) begin
                    mDone   = 1;
                    mFits   = pendFits;
                    mResult = pendResult;
                    if (!pendFits && mOvf < 255) mOvf = mOvf + 1;
                end
            end else if (busIf.start) begin
                v = $signed(busIf.data_in);
                pendFits = (v >= -32) && (v <= 31);
                if (pendFits || !busIf.sat_en) pendResult = busIf.data_in[5:0];
                else pendResult = (v < 0) ? 6'h20 : 6'h1F;
                mBusyLeft = N;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        if (checkEn) begin
            checkOutput("busy",      32'(busIf.busy),       32'(mBusyLeft > 0));
            checkOutput("done",      32'(busIf.done),       32'(mDone));
            checkOutput("result",    32'(busIf.result_out), 32'(mResult));
            checkOutput("fits",      32'(busIf.fits),       32'(mFits));
            checkOutput("ovf_count", 32'(busIf.ovf_count),  32'(mOvf));
            if (busIf.done) doneSeen++;
        end
    end

    task automatic applyStimulus(input logic [31:0] data, input logic sat);
        busIf.start   = 1'b1;
        busIf.data_in = data;
        busIf.sat_en  = sat;
        @(posedge clk);
        #1 busIf.start = 1'b0;
    endtask

    task automatic waitDone(output int cycles);
        cycles = 0;
        while (1) begin
            @(posedge clk);
            cycles++;
            @(negedge clk);
            if (busIf.done) break;
            if (cycles > N + 10) begin
                compared++;
                mismatched++;
                $display("[TB] FAIL done timeout: got no done after %0d cycles, expected %0d", cycles, N);
                break;
            end
        end
    endtask

    task automatic convertAndCheck(input string name, input logic [31:0] data, input logic sat,
                                   input logic [5:0] expRes, input logic expFits, input int expOvf);
        int cyc;
        applyStimulus(data, sat);
        waitDone(cyc);
        checkOutput({name, " latency"}, 32'(cyc), 32'(N));
        checkOutput({name, " result"},  32'(busIf.result_out), 32'(expRes));
        checkOutput({name, " fits"},    32'(busIf.fits), 32'(expFits));
        checkOutput({name, " ovf"},     32'(busIf.ovf_count), 32'(expOvf));
    endtask

    initial begin
        int cyc;
        int doneBefore;
        compared      = 0;
        mismatched    = 0;
        checkEn       = 0;
        doneSeen      = 0;
        reset         = 1'b1;
        busIf.start   = 1'b0;
        busIf.data_in = '0;
        busIf.sat_en  = 1'b0;
        repeat (3) @(posedge clk);
        checkEn = 1;
        @(negedge clk);
        reset = 1'b0;
        checkOutput("reset busy",   32'(busIf.busy), 32'd0);
        checkOutput("reset done",   32'(busIf.done), 32'd0);
        checkOutput("reset result", 32'(busIf.result_out), 32'd0);
        checkOutput("reset fits",   32'(busIf.fits), 32'd0);
        checkOutput("reset ovf",    32'(busIf.ovf_count), 32'd0);

        convertAndCheck("pos31",      32'h0000001F, 1'b0, 6'h1F, 1'b1, 0);
        convertAndCheck("neg32",      32'hFFFFFFE0, 1'b0, 6'h20, 1'b1, 0);
        convertAndCheck("pos32 trunc", 32'h00000020, 1'b0, 6'h20, 1'b0, 1);
        convertAndCheck("pos32 sat",  32'h00000020, 1'b1, 6'h1F, 1'b0, 2);
        convertAndCheck("minint sat", 32'h80000000, 1'b1, 6'h20, 1'b0, 3);
        convertAndCheck("neg33 sat",  32'hFFFFFFDF, 1'b1, 6'h20, 1'b0, 4);
        convertAndCheck("topbit trunc", 32'h4000001F, 1'b0, 6'h1F, 1'b0, 5);

        // Start while busy is ignored; start in the done cycle is accepted.
        applyStimulus(32'h00000005, 1'b0);
        repeat (4) @(posedge clk);
        busIf.start   = 1'b1;
        busIf.data_in = 32'h12345678;
        busIf.sat_en  = 1'b1;
        @(posedge clk);
        #1 busIf.start = 1'b0;
        waitDone(cyc);
        checkOutput("ignore latency", 32'(cyc), 32'(N - 5));
        checkOutput("ignore result",  32'(busIf.result_out), 32'h05);
        checkOutput("ignore fits",    32'(busIf.fits), 32'd1);
        convertAndCheck("b2b", 32'hFFFFFFFF, 1'b0, 6'h3F, 1'b1, 5);

        // Reset in mid-scan aborts without a done pulse.
        applyStimulus(32'h00000100, 1'b1);
        repeat (10) @(posedge clk);
        @(negedge clk);
        doneBefore = doneSeen;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checkOutput("abort busy",   32'(busIf.busy), 32'd0);
        checkOutput("abort result", 32'(busIf.result_out), 32'd0);
        checkOutput("abort fits",   32'(busIf.fits), 32'd0);
        checkOutput("abort ovf",    32'(busIf.ovf_count), 32'd0);
        repeat (N + 4) @(negedge clk);
        checkOutput("abort no done", 32'(doneSeen - doneBefore), 32'd0);
        convertAndCheck("after abort", 32'h0000001F, 1'b0, 6'h1F, 1'b1, 0);

        // Saturating overflow counter.
        for (int i = 1; i <= 300; i++) begin
            applyStimulus(32'h7FFFFFFF, 1'b0);
            waitDone(cyc);
            if (i == 255 || i == 256 || i == 300) begin
                checkOutput("sat ovf", 32'(busIf.ovf_count), 32'(i < 255 ? i : 255));
                checkOutput("sat result", 32'(busIf.result_out), 32'h3F);
            end
        end

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
